// File: rtl/climate_predictor_mc_pkg.sv
// Shared types for the multi-channel climate predictor: condition codes and FSM states.
package climate_pkg;

    localparam int COND_W = 3;

    typedef enum logic [COND_W-1:0] {
        NONE       = 3'd0,
        STORM      = 3'd1,
        HOT_CLEAR  = 3'd2,
        COLD_CLEAR = 3'd3,
        HOT        = 3'd4,
        COLD       = 3'd5,
        MILD       = 3'd6,
        ERR        = 3'd7
    } cond_e;

    typedef enum logic [1:0] {
        IDLE,
        UPDATE,
        CLASSIFY,
        OUTPUT
    } state_e;

endpackage

// File: rtl/climate_predictor_mc_if.sv
// Sample-in / result-out handshake bundle for the climate predictor, plus the flush control.
interface climate_predictor_mc_if
    import climate_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CH_W   = 2
);
    logic                     flush;
    logic                     in_valid;
    logic                     in_ready;
    logic [CH_W-1:0]          in_ch;
    logic signed [DATA_W-1:0] temperature;
    logic [DATA_W-1:0]        pressure;
    logic                     out_valid;
    logic                     out_ready;
    logic [CH_W-1:0]          out_ch;
    logic [COND_W-1:0]        climate_condition;
    logic signed [DATA_W-1:0] avg_temperature;
    logic [DATA_W-1:0]        avg_pressure;
    logic                     done;

    modport master (
        output flush, in_valid, in_ch, temperature, pressure, out_ready,
        input  in_ready, out_valid, out_ch, climate_condition,
               avg_temperature, avg_pressure, done
    );

    modport slave (
        input  flush, in_valid, in_ch, temperature, pressure, out_ready,
        output in_ready, out_valid, out_ch, climate_condition,
               avg_temperature, avg_pressure, done
    );
endinterface

// File: rtl/climate_predictor_mc_window.sv
// One channel's sliding window: ring buffer of the last WIN samples with running sums.
module climate_window #(
    parameter int DATA_W = 32,
    parameter int WIN    = 8,
    parameter int LW     = $clog2(WIN),
    parameter int SUM_W  = DATA_W + LW
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     upd,
    input  logic signed [DATA_W-1:0] t_in,
    input  logic [DATA_W-1:0]        p_in,
    output logic signed [SUM_W-1:0]  sum_t,
    output logic [SUM_W-1:0]         sum_p,
    output logic                     full
);
    logic signed [DATA_W-1:0] buf_t [WIN];
    logic [DATA_W-1:0]        buf_p [WIN];
    logic [LW-1:0]            wr_ptr;
    logic [LW:0]              fill;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < WIN; i++) begin
                buf_t[i] <= '0;
                buf_p[i] <= '0;
            end
            sum_t  <= '0;
            sum_p  <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else if (upd) begin
            // Replace the oldest entry; the sums track add-new / drop-old so no re-summing is needed
            buf_t[wr_ptr] <= t_in;
            buf_p[wr_ptr] <= p_in;
            sum_t  <= sum_t + SUM_W'(t_in) - SUM_W'(buf_t[wr_ptr]);
            sum_p  <= sum_p + SUM_W'(p_in) - SUM_W'(buf_p[wr_ptr]);
            wr_ptr <= wr_ptr + 1'b1;
            if (fill != (LW+1)'(WIN))
                fill <= fill + 1'b1;
        end
    end

    assign full = (fill == (LW+1)'(WIN));
endmodule

// File: rtl/climate_predictor_mc.sv
// Multi-channel climate predictor: per-channel windowed averages classified into a condition code.
module climate_predictor_mc
    import climate_pkg::*;
#(
    parameter int                       NUM_CH = 4,
    parameter int                       DATA_W = 32,
    parameter int                       WIN    = 8,
    parameter logic signed [DATA_W-1:0] T_HOT  = 30,
    parameter logic signed [DATA_W-1:0] T_COLD = 5,
    parameter logic [DATA_W-1:0]        P_LOW  = 980,
    parameter logic [DATA_W-1:0]        P_HIGH = 1020
) (
    input logic             clk,
    input logic             rst,
    climate_predictor_mc_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int LW    = $clog2(WIN);
    localparam int SUM_W = DATA_W + LW;

    function automatic cond_e classify(input logic ok, input logic full,
                                       input logic signed [DATA_W-1:0] at,
                                       input logic [DATA_W-1:0] ap);
        if (!ok)                        return ERR;
        else if (!full)                 return NONE;
        else if (ap < P_LOW)            return STORM;
        else if (at > T_HOT && ap > P_HIGH)  return HOT_CLEAR;
        else if (at < T_COLD && ap > P_HIGH) return COLD_CLEAR;
        else if (at > T_HOT)            return HOT;
        else if (at < T_COLD)           return COLD;
        else                            return MILD;
    endfunction

    state_e                   state, state_nx;
    logic                     ready_q;
    logic [CH_W-1:0]          ch_q;
    logic signed [DATA_W-1:0] t_q;
    logic [DATA_W-1:0]        p_q;
    logic                     accept, ch_ok;
    logic [NUM_CH-1:0]        upd, full;
    logic signed [SUM_W-1:0]  sum_t [NUM_CH];
    logic [SUM_W-1:0]         sum_p [NUM_CH];
    logic signed [SUM_W-1:0]  sel_t;
    logic [SUM_W-1:0]         sel_p;
    logic                     sel_full;
    logic signed [DATA_W-1:0] avg_t_nx;
    logic [DATA_W-1:0]        avg_p_nx;
    logic [CH_W-1:0]          out_ch_q;
    logic [COND_W-1:0]        cond_q;
    logic signed [DATA_W-1:0] avg_t_q;
    logic [DATA_W-1:0]        avg_p_q;

    assign accept = bus.in_valid & bus.in_ready;
    assign ch_ok  = int'(ch_q) < NUM_CH;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_win
        assign upd[c] = (state == UPDATE) && ch_ok && (int'(ch_q) == c);
        climate_window #(.DATA_W(DATA_W), .WIN(WIN)) u_win (
            .clk   (clk),
            .rst   (rst),
            .clr   (bus.flush),
            .upd   (upd[c]),
            .t_in  (t_q),
            .p_in  (p_q),
            .sum_t (sum_t[c]),
            .sum_p (sum_p[c]),
            .full  (full[c])
        );
    end

    // Channel select by compare rather than index so an out-of-range id reads as zero
    always_comb begin
        sel_t    = '0;
        sel_p    = '0;
        sel_full = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (int'(ch_q) == i) begin
                sel_t    = sum_t[i];
                sel_p    = sum_p[i];
                sel_full = full[i];
            end
        end
        avg_t_nx = DATA_W'(sel_t >>> LW);
        avg_p_nx = DATA_W'(sel_p >> LW);
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (accept) state_nx = UPDATE;
            UPDATE:   state_nx = CLASSIFY;
            CLASSIFY: state_nx = OUTPUT;
            OUTPUT:   if (bus.out_ready) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
        if (bus.flush)
            state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready_q  <= 1'b0;
            out_ch_q <= '0;
            cond_q   <= '0;
            avg_t_q  <= '0;
            avg_p_q  <= '0;
        end else begin
            state   <= state_nx;
            ready_q <= (state_nx == IDLE);
            if (state == CLASSIFY && !bus.flush) begin
                out_ch_q <= ch_q;
                cond_q   <= classify(ch_ok, sel_full, avg_t_nx, avg_p_nx);
                avg_t_q  <= ch_ok ? avg_t_nx : '0;
                avg_p_q  <= ch_ok ? avg_p_nx : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            ch_q <= bus.in_ch;
            t_q  <= bus.temperature;
            p_q  <= bus.pressure;
        end
    end

    assign bus.in_ready          = ready_q & ~bus.flush;
    assign bus.out_valid         = (state == OUTPUT);
    assign bus.done              = (state == OUTPUT) & bus.out_ready & ~bus.flush;
    assign bus.out_ch            = out_ch_q;
    assign bus.climate_condition = cond_q;
    assign bus.avg_temperature   = avg_t_q;
    assign bus.avg_pressure      = avg_p_q;
endmodule

// File: tb/tb_climate_predictor_mc.sv
// Directed bench for climate_predictor_mc: window fill, floor averaging, priority, backpressure, flush, ERR.
module tb_climate_predictor_mc;
    localparam int W = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    climate_predictor_mc_if #(.DATA_W(32), .CH_W(2)) bus ();
    climate_predictor_mc_if #(.DATA_W(32), .CH_W(2)) bus3 ();

    climate_predictor_mc #(.NUM_CH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
    climate_predictor_mc #(.NUM_CH(3)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    int compares = 0;
    int fails    = 0;
    int mt [4][W];
    int mp [4][W];
    int mptr [4];
    int mfill [4];
    int last_c, last_t, last_p;

    task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        compares++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int c = 0; c < 4; c++) begin
            for (int i = 0; i < W; i++) begin
                mt[c][i] = 0;
                mp[c][i] = 0;
            end
            mptr[c]  = 0;
            mfill[c] = 0;
        end
    endtask

    function automatic int ref_cond(input int fill, input int at, input int ap);
        if (fill < W)                 return 0;
        if (ap < 980)                 return 1;
        if (at > 30 && ap > 1020)     return 2;
        if (at < 5 && ap > 1020)      return 3;
        if (at > 30)                  return 4;
        if (at < 5)                   return 5;
        return 6;
    endfunction

    task automatic model_push(input int ch, input int t, input int p,
                              output int et, output int ep, output int ec);
        longint st, sp;
        mt[ch][mptr[ch]] = t;
        mp[ch][mptr[ch]] = p;
        mptr[ch] = (mptr[ch] + 1) % W;
        if (mfill[ch] < W) mfill[ch]++;
        st = 0;
        sp = 0;
        for (int i = 0; i < W; i++) begin
            st += mt[ch][i];
            sp += mp[ch][i];
        end
        et = (st >= 0) ? int'(st / W) : -int'((-st + W - 1) / W);
        ep = int'(sp / W);
        ec = ref_cond(mfill[ch], et, ep);
    endtask

    task automatic send(input int ch, input int t, input int p, input string tag);
        int et, ep, ec, n;
        n = 0;
        while (!bus.in_ready && n < 20) begin tick(); n++; end
        check({tag, " in_ready"}, bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_ch = 2'(ch);
        bus.temperature = t;
        bus.pressure = p;
        tick();
        bus.in_valid = 1'b0;
        model_push(ch, t, p, et, ep, ec);
        n = 0;
        while (!bus.out_valid && n < 10) begin tick(); n++; end
        check({tag, " latency"}, n, 2);
        check({tag, " out_ch"}, bus.out_ch, ch);
        check({tag, " cond"}, bus.climate_condition, ec);
        check({tag, " avg_t"}, bus.avg_temperature, et);
        check({tag, " avg_p"}, bus.avg_pressure, ep);
        check({tag, " done"}, bus.done, 1);
        last_c = int'(bus.climate_condition);
        last_t = int'(bus.avg_temperature);
        last_p = int'(bus.avg_pressure);
        tick();
    endtask

    initial begin
        int et, ep, ec, n;
        model_clear();
        rst = 1'b1;
        bus.flush = 0; bus.in_valid = 1; bus.in_ch = 0; bus.temperature = 99;
        bus.pressure = 999; bus.out_ready = 1;
        bus3.flush = 0; bus3.in_valid = 0; bus3.in_ch = 0; bus3.temperature = 0;
        bus3.pressure = 0; bus3.out_ready = 1;

        // Reset held with a sample pending
        repeat (3) tick();
        check("rst out_valid", bus.out_valid, 0);
        check("rst done", bus.done, 0);
        check("rst in_ready", bus.in_ready, 0);
        check("rst cond", bus.climate_condition, 0);
        check("rst avg_t", bus.avg_temperature, 0);
        check("rst avg_p", bus.avg_pressure, 0);
        rst = 1'b0;
        tick();
        bus.in_valid = 1'b0;
        check("post-rst in_ready", bus.in_ready, 1);
        repeat (3) tick();
        check("post-rst no accept", bus.out_valid, 0);

        // Window fill on ch0
        for (int k = 1; k <= 8; k++) send(0, 35, 1030, $sformatf("ch0 fill%0d", k));
        check("ch0 full cond", last_c, 2);
        check("ch0 full avg_t", last_t, 35);
        check("ch0 full avg_p", last_p, 1030);

        // Signed floor: seven 0s and one -1 averages to -1
        for (int k = 1; k <= 7; k++) send(1, 0, 1000, $sformatf("ch1 zero%0d", k));
        send(1, -1, 1000, "ch1 neg1");
        check("ch1 floor avg_t", last_t, -1);
        check("ch1 floor cond", last_c, 5);
        for (int k = 1; k <= 8; k++) send(1, -3, 1000, $sformatf("ch1 slide%0d", k));
        check("ch1 slid avg_t", last_t, -3);
        check("ch1 slid cond", last_c, 5);

        // Storm priority beats HOT; other channels untouched
        for (int k = 1; k <= 8; k++) send(2, 40, 900, $sformatf("ch2 fill%0d", k));
        check("ch2 storm cond", last_c, 1);
        send(3, 20, 1000, "ch3 single");
        check("ch3 cond", last_c, 0);
        check("ch3 avg_t", last_t, 2);
        check("ch3 avg_p", last_p, 125);
        send(2, 40, 900, "ch2 again");
        check("ch2 iso avg_t", last_t, 40);
        check("ch2 iso avg_p", last_p, 900);

        // Backpressure
        bus.out_ready = 1'b0;
        n = 0;
        while (!bus.in_ready && n < 20) begin tick(); n++; end
        bus.in_valid = 1; bus.in_ch = 0; bus.temperature = 35; bus.pressure = 1030;
        tick();
        bus.in_valid = 0;
        model_push(0, 35, 1030, et, ep, ec);
        n = 0;
        while (!bus.out_valid && n < 10) begin tick(); n++; end
        check("bp latency", n, 2);
        check("bp cond", bus.climate_condition, 2);
        bus.in_valid = 1; bus.in_ch = 1; bus.temperature = 7; bus.pressure = 7;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp hold valid", bus.out_valid, 1);
            check("bp hold in_ready", bus.in_ready, 0);
            check("bp hold done", bus.done, 0);
            check("bp hold avg_t", bus.avg_temperature, 35);
            check("bp hold avg_p", bus.avg_pressure, 1030);
        end
        bus.in_valid = 0;
        bus.out_ready = 1;
        #1;
        check("bp done pulse", bus.done, 1);
        tick();
        check("bp done clear", bus.done, 0);
        check("bp valid clear", bus.out_valid, 0);
        check("bp in_ready back", bus.in_ready, 1);
        tick();
        check("bp no stray accept", bus.out_valid, 0);

        // Flush while in CLASSIFY
        bus.in_valid = 1; bus.in_ch = 0; bus.temperature = 35; bus.pressure = 1030;
        tick();
        bus.in_valid = 0;
        tick();
        bus.flush = 1;
        tick();
        bus.flush = 0;
        model_clear();
        for (int k = 0; k < 4; k++) begin
            check("flush no result", bus.out_valid, 0);
            tick();
        end
        // Flush in IDLE blocks acceptance
        bus.flush = 1; bus.in_valid = 1;
        #1;
        check("flush in_ready", bus.in_ready, 0);
        tick();
        bus.flush = 0; bus.in_valid = 0;
        tick();
        tick();
        check("flush idle no accept", bus.out_valid, 0);
        send(0, 35, 1030, "ch0 post-flush");
        check("post-flush cond", last_c, 0);
        check("post-flush avg_t", last_t, 4);
        check("post-flush avg_p", last_p, 128);

        // Out-of-range channel with NUM_CH=3
        n = 0;
        while (!bus3.in_ready && n < 20) begin tick(); n++; end
        bus3.in_valid = 1; bus3.in_ch = 3; bus3.temperature = 50; bus3.pressure = 1000;
        tick();
        bus3.in_valid = 0;
        n = 0;
        while (!bus3.out_valid && n < 10) begin tick(); n++; end
        check("err latency", n, 2);
        check("err cond", bus3.climate_condition, 7);
        check("err out_ch", bus3.out_ch, 3);
        check("err avg_t", bus3.avg_temperature, 0);
        check("err avg_p", bus3.avg_pressure, 0);
        tick();
        bus3.in_valid = 1; bus3.in_ch = 2; bus3.temperature = 16; bus3.pressure = 800;
        tick();
        bus3.in_valid = 0;
        n = 0;
        while (!bus3.out_valid && n < 10) begin tick(); n++; end
        check("n3 ch2 cond", bus3.climate_condition, 0);
        check("n3 ch2 avg_t", bus3.avg_temperature, 2);
        check("n3 ch2 avg_p", bus3.avg_pressure, 100);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, fails);
        $finish;
    end
endmodule
